// File: rtl/axi_regslice_if.sv
// AXI4 channel bundle shared by both sides of axi_regslice.
// The master modport drives AW/W/AR and the B/R ready; the slave modport is its mirror.
interface axi_channel #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int AW_USER_WIDTH = 1,
  parameter int W_USER_WIDTH  = 1,
  parameter int B_USER_WIDTH  = 1,
  parameter int AR_USER_WIDTH = 1,
  parameter int R_USER_WIDTH  = 1
);
  logic [ID_WIDTH-1:0]      aw_id;
  logic [ADDR_WIDTH-1:0]    aw_addr;
  logic [7:0]               aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic                     aw_lock;
  logic [3:0]               aw_cache;
  logic [2:0]               aw_prot;
  logic [3:0]               aw_qos;
  logic [AW_USER_WIDTH-1:0] aw_user;
  logic                     aw_valid;
  logic                     aw_ready;

  logic [DATA_WIDTH-1:0]    w_data;
  logic [DATA_WIDTH/8-1:0]  w_strb;
  logic                     w_last;
  logic [W_USER_WIDTH-1:0]  w_user;
  logic                     w_valid;
  logic                     w_ready;

  logic [ID_WIDTH-1:0]      b_id;
  logic [1:0]               b_resp;
  logic [B_USER_WIDTH-1:0]  b_user;
  logic                     b_valid;
  logic                     b_ready;

  logic [ID_WIDTH-1:0]      ar_id;
  logic [ADDR_WIDTH-1:0]    ar_addr;
  logic [7:0]               ar_len;
  logic [2:0]               ar_size;
  logic [1:0]               ar_burst;
  logic                     ar_lock;
  logic [3:0]               ar_cache;
  logic [2:0]               ar_prot;
  logic [3:0]               ar_qos;
  logic [AR_USER_WIDTH-1:0] ar_user;
  logic                     ar_valid;
  logic                     ar_ready;

  logic [ID_WIDTH-1:0]      r_id;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [1:0]               r_resp;
  logic                     r_last;
  logic [R_USER_WIDTH-1:0]  r_user;
  logic                     r_valid;
  logic                     r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
           ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_user, ar_valid, r_ready,
    input  aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_user, r_valid
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
           ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_user, ar_valid, r_ready,
    output aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
           r_id, r_data, r_resp, r_last, r_user, r_valid
  );
endinterface

// File: rtl/axi_regslice.sv
// AXI4 register slice with an independent pipeline mode per channel (0 bypass, 1 forward, 2 full, 3 half).
// Define AXI_REGSLICE_CHECK_EN to compile in the per-channel protocol checker and err_count.
module axi_regslice_chan #(
  parameter int MODE = 2,
  parameter int W    = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  case (MODE)
    0: begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk_i, rst_i};
      assign out_valid_o   = in_valid_i;
      assign out_data_o    = in_data_i;
      assign in_ready_o    = out_ready_i;
    end
    1: begin : g_forward
      logic         valid_q, valid_d;
      logic [W-1:0] data_q, data_d;
      assign in_ready_o = !valid_q || out_ready_i;
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
          valid_d = 1'b1;
          data_d  = in_data_i;
        end else if (out_ready_i) begin
          valid_d = 1'b0;
        end
      end
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end
      assign out_valid_o = valid_q;
      assign out_data_o  = data_q;
    end
    3: begin : g_half
      logic         valid_q, valid_d, ready_q;
      logic [W-1:0] data_q, data_d;
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q) begin
          if (out_ready_i) valid_d = 1'b0;
        end else if (in_valid_i && ready_q) begin
          valid_d = 1'b1;
          data_d  = in_data_i;
        end
      end
      // ready is its own flop so it reads 0 throughout reset, not just !valid
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= 1'b0;
          ready_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          ready_q <= !valid_d;
          data_q  <= data_d;
        end
      end
      assign in_ready_o  = ready_q;
      assign out_valid_o = valid_q;
      assign out_data_o  = data_q;
    end
    default: begin : g_full
      // state | meaning: EMPTY no beat held, ONE beat in main, TWO beats in main+skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;
      logic [1:0]   state_q, state_d;
      logic [W-1:0] main_q, main_d, skid_q, skid_d;
      logic         ready_q, in_hs, out_hs;
      assign in_hs  = in_valid_i && ready_q;
      assign out_hs = (state_q != ST_EMPTY) && out_ready_i;
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          ST_EMPTY: if (in_hs) begin
            state_d = ST_ONE;
            main_d  = in_data_i;
          end
          ST_ONE: begin
            if (in_hs && out_hs) begin
              main_d = in_data_i;
            end else if (in_hs) begin
              state_d = ST_TWO;
              skid_d  = in_data_i;
            end else if (out_hs) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: if (out_hs) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= (state_d != ST_TWO);
        end
      end
      assign in_ready_o  = ready_q;
      assign out_valid_o = (state_q != ST_EMPTY);
      assign out_data_o  = main_q;
    end
  endcase
endmodule

`ifdef AXI_REGSLICE_CHECK_EN
module axi_regslice_chk #(
  parameter int W    = 1,
  parameter int PORT = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         viol_o
);
  logic         pv_q, pr_q, stall;
  logic [W-1:0] pd_q;
  assign stall  = pv_q && !pr_q;
  assign viol_o = !rst_i && ((stall && !valid_i) || (stall && valid_i && (data_i != pd_q)) ||
                             $isunknown({valid_i, ready_i}));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv_q <= 1'b0;
      pr_q <= 1'b0;
      pd_q <= '0;
    end else begin
      pv_q <= valid_i;
      pr_q <= ready_i;
      pd_q <= data_i;
      if (viol_o) $error("axi_regslice: protocol violation on checker port %0d", PORT);
    end
  end
endmodule
`endif

module axi_regslice #(
  parameter int AW_MODE = 2,
  parameter int W_MODE  = 2,
  parameter int B_MODE  = 2,
  parameter int AR_MODE = 2,
  parameter int R_MODE  = 2
) (
  input logic        clk,
  input logic        rst,
  axi_channel.slave  master,
  axi_channel.master slave
);
  localparam int MID = master.ID_WIDTH;
  localparam int SID = slave.ID_WIDTH;
  localparam int SAD = slave.ADDR_WIDTH;
  localparam int DW  = slave.DATA_WIDTH;
  localparam int AWU = slave.AW_USER_WIDTH;
  localparam int WU  = slave.W_USER_WIDTH;
  localparam int BU  = slave.B_USER_WIDTH;
  localparam int ARU = slave.AR_USER_WIDTH;
  localparam int RU  = slave.R_USER_WIDTH;

  if (master.ID_WIDTH > slave.ID_WIDTH || master.DATA_WIDTH != slave.DATA_WIDTH ||
      master.AW_USER_WIDTH != slave.AW_USER_WIDTH || master.W_USER_WIDTH != slave.W_USER_WIDTH ||
      master.B_USER_WIDTH != slave.B_USER_WIDTH || master.AR_USER_WIDTH != slave.AR_USER_WIDTH ||
      master.R_USER_WIDTH != slave.R_USER_WIDTH || AW_MODE > 3 || W_MODE > 3 || B_MODE > 3 ||
      AR_MODE > 3 || R_MODE > 3) begin : g_param_check
    $fatal(1, "Interface parameters mismatch");
  end

  localparam int AXP = SID + SAD + 25 + AWU;
  localparam int ARP = SID + SAD + 25 + ARU;
  localparam int WP  = DW + DW / 8 + 1 + WU;
  localparam int BP  = MID + 2 + BU;
  localparam int RP  = MID + DW + 3 + RU;

  logic [AXP-1:0] aw_in, aw_out;
  logic [WP-1:0]  w_in, w_out;
  logic [BP-1:0]  b_in, b_out;
  logic [ARP-1:0] ar_in, ar_out;
  logic [RP-1:0]  r_in, r_out;

  // Width adaptation happens on the source side so each slice stores sink-width payload
  assign aw_in = {SID'(master.aw_id), SAD'(master.aw_addr), master.aw_len, master.aw_size,
                  master.aw_burst, master.aw_lock, master.aw_cache, master.aw_prot,
                  master.aw_qos, master.aw_user};
  assign {slave.aw_id, slave.aw_addr, slave.aw_len, slave.aw_size, slave.aw_burst,
          slave.aw_lock, slave.aw_cache, slave.aw_prot, slave.aw_qos, slave.aw_user} = aw_out;
  assign ar_in = {SID'(master.ar_id), SAD'(master.ar_addr), master.ar_len, master.ar_size,
                  master.ar_burst, master.ar_lock, master.ar_cache, master.ar_prot,
                  master.ar_qos, master.ar_user};
  assign {slave.ar_id, slave.ar_addr, slave.ar_len, slave.ar_size, slave.ar_burst,
          slave.ar_lock, slave.ar_cache, slave.ar_prot, slave.ar_qos, slave.ar_user} = ar_out;
  assign w_in  = {master.w_data, master.w_strb, master.w_last, master.w_user};
  assign {slave.w_data, slave.w_strb, slave.w_last, slave.w_user} = w_out;
  assign b_in  = {MID'(slave.b_id), slave.b_resp, slave.b_user};
  assign {master.b_id, master.b_resp, master.b_user} = b_out;
  assign r_in  = {MID'(slave.r_id), slave.r_data, slave.r_resp, slave.r_last, slave.r_user};
  assign {master.r_id, master.r_data, master.r_resp, master.r_last, master.r_user} = r_out;

  logic unused_trunc;
  assign unused_trunc = ^{master.aw_addr, master.ar_addr, slave.b_id, slave.r_id};

  axi_regslice_chan #(.MODE(AW_MODE), .W(AXP)) u_aw (
    .clk_i(clk), .rst_i(rst), .in_valid_i(master.aw_valid), .in_ready_o(master.aw_ready),
    .in_data_i(aw_in), .out_valid_o(slave.aw_valid), .out_ready_i(slave.aw_ready),
    .out_data_o(aw_out));
  axi_regslice_chan #(.MODE(W_MODE), .W(WP)) u_w (
    .clk_i(clk), .rst_i(rst), .in_valid_i(master.w_valid), .in_ready_o(master.w_ready),
    .in_data_i(w_in), .out_valid_o(slave.w_valid), .out_ready_i(slave.w_ready),
    .out_data_o(w_out));
  axi_regslice_chan #(.MODE(B_MODE), .W(BP)) u_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(slave.b_valid), .in_ready_o(slave.b_ready),
    .in_data_i(b_in), .out_valid_o(master.b_valid), .out_ready_i(master.b_ready),
    .out_data_o(b_out));
  axi_regslice_chan #(.MODE(AR_MODE), .W(ARP)) u_ar (
    .clk_i(clk), .rst_i(rst), .in_valid_i(master.ar_valid), .in_ready_o(master.ar_ready),
    .in_data_i(ar_in), .out_valid_o(slave.ar_valid), .out_ready_i(slave.ar_ready),
    .out_data_o(ar_out));
  axi_regslice_chan #(.MODE(R_MODE), .W(RP)) u_r (
    .clk_i(clk), .rst_i(rst), .in_valid_i(slave.r_valid), .in_ready_o(slave.r_ready),
    .in_data_i(r_in), .out_valid_o(master.r_valid), .out_ready_i(master.r_ready),
    .out_data_o(r_out));

`ifdef AXI_REGSLICE_CHECK_EN
  logic [9:0]  viol;
  logic [31:0] err_count;
  axi_regslice_chk #(.W(AXP), .PORT(0)) u_chk_aw_m (.clk_i(clk), .rst_i(rst),
    .valid_i(master.aw_valid), .ready_i(master.aw_ready), .data_i(aw_in), .viol_o(viol[0]));
  axi_regslice_chk #(.W(AXP), .PORT(1)) u_chk_aw_s (.clk_i(clk), .rst_i(rst),
    .valid_i(slave.aw_valid), .ready_i(slave.aw_ready), .data_i(aw_out), .viol_o(viol[1]));
  axi_regslice_chk #(.W(WP), .PORT(2)) u_chk_w_m (.clk_i(clk), .rst_i(rst),
    .valid_i(master.w_valid), .ready_i(master.w_ready), .data_i(w_in), .viol_o(viol[2]));
  axi_regslice_chk #(.W(WP), .PORT(3)) u_chk_w_s (.clk_i(clk), .rst_i(rst),
    .valid_i(slave.w_valid), .ready_i(slave.w_ready), .data_i(w_out), .viol_o(viol[3]));
  axi_regslice_chk #(.W(BP), .PORT(4)) u_chk_b_s (.clk_i(clk), .rst_i(rst),
    .valid_i(slave.b_valid), .ready_i(slave.b_ready), .data_i(b_in), .viol_o(viol[4]));
  axi_regslice_chk #(.W(BP), .PORT(5)) u_chk_b_m (.clk_i(clk), .rst_i(rst),
    .valid_i(master.b_valid), .ready_i(master.b_ready), .data_i(b_out), .viol_o(viol[5]));
  axi_regslice_chk #(.W(ARP), .PORT(6)) u_chk_ar_m (.clk_i(clk), .rst_i(rst),
    .valid_i(master.ar_valid), .ready_i(master.ar_ready), .data_i(ar_in), .viol_o(viol[6]));
  axi_regslice_chk #(.W(ARP), .PORT(7)) u_chk_ar_s (.clk_i(clk), .rst_i(rst),
    .valid_i(slave.ar_valid), .ready_i(slave.ar_ready), .data_i(ar_out), .viol_o(viol[7]));
  axi_regslice_chk #(.W(RP), .PORT(8)) u_chk_r_s (.clk_i(clk), .rst_i(rst),
    .valid_i(slave.r_valid), .ready_i(slave.r_ready), .data_i(r_in), .viol_o(viol[8]));
  axi_regslice_chk #(.W(RP), .PORT(9)) u_chk_r_m (.clk_i(clk), .rst_i(rst),
    .valid_i(master.r_valid), .ready_i(master.r_ready), .data_i(r_out), .viol_o(viol[9]));

  // One count per offending cycle, saturating
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (|viol && err_count != '1) err_count <= err_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_axi_regslice.sv
// Directed bench for axi_regslice: one mixed-mode instance and one all-bypass instance.
module tb_axi_regslice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AW_USER_WIDTH(2),
    .W_USER_WIDTH(2), .B_USER_WIDTH(2), .AR_USER_WIDTH(2), .R_USER_WIDTH(2)) m_if ();
  axi_channel #(.ID_WIDTH(6), .ADDR_WIDTH(16), .DATA_WIDTH(32), .AW_USER_WIDTH(2),
    .W_USER_WIDTH(2), .B_USER_WIDTH(2), .AR_USER_WIDTH(2), .R_USER_WIDTH(2)) s_if ();
  axi_channel #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AW_USER_WIDTH(2),
    .W_USER_WIDTH(2), .B_USER_WIDTH(2), .AR_USER_WIDTH(2), .R_USER_WIDTH(2)) m_b ();
  axi_channel #(.ID_WIDTH(6), .ADDR_WIDTH(16), .DATA_WIDTH(32), .AW_USER_WIDTH(2),
    .W_USER_WIDTH(2), .B_USER_WIDTH(2), .AR_USER_WIDTH(2), .R_USER_WIDTH(2)) s_b ();

  axi_regslice #(.AW_MODE(0), .W_MODE(2), .B_MODE(1), .AR_MODE(3), .R_MODE(2)) dut (
    .clk(clk), .rst(rst), .master(m_if), .slave(s_if));
  axi_regslice #(.AW_MODE(0), .W_MODE(0), .B_MODE(0), .AR_MODE(0), .R_MODE(0)) dut_byp (
    .clk(clk), .rst(rst), .master(m_b), .slave(s_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    m_if.aw_valid = 0; m_if.w_valid = 0; m_if.ar_valid = 0; m_if.b_ready = 0; m_if.r_ready = 0;
    s_if.aw_ready = 0; s_if.w_ready = 0; s_if.ar_ready = 0; s_if.b_valid = 0; s_if.r_valid = 0;
    m_b.aw_valid = 0; m_b.w_valid = 0; m_b.ar_valid = 0; m_b.b_ready = 0; m_b.r_ready = 0;
    s_b.aw_ready = 0; s_b.w_ready = 0; s_b.ar_ready = 0; s_b.b_valid = 0; s_b.r_valid = 0;
    rst = 1;
    tick();
    tick();
    settle();
    n_total++; if (s_if.w_valid !== 1'b0) $display("FAIL rst_w_valid got %b exp 0", s_if.w_valid); else n_pass++;
    n_total++; if (m_if.w_ready !== 1'b0) $display("FAIL rst_w_ready got %b exp 0", m_if.w_ready); else n_pass++;
    n_total++; if (m_if.ar_ready !== 1'b0) $display("FAIL rst_ar_ready got %b exp 0", m_if.ar_ready); else n_pass++;
    n_total++; if (m_if.r_valid !== 1'b0) $display("FAIL rst_r_valid got %b exp 0", m_if.r_valid); else n_pass++;
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL rst_b_valid got %b exp 0", m_if.b_valid); else n_pass++;
    n_total++; if (s_if.r_ready !== 1'b0) $display("FAIL rst_r_ready got %b exp 0", s_if.r_ready); else n_pass++;
    rst = 0;
    tick();
    settle();
    n_total++; if (m_if.w_ready !== 1'b1) $display("FAIL post_rst_w_ready got %b exp 1", m_if.w_ready); else n_pass++;
    n_total++; if (m_if.ar_ready !== 1'b1) $display("FAIL post_rst_ar_ready got %b exp 1", m_if.ar_ready); else n_pass++;
    n_total++; if (s_if.r_ready !== 1'b1) $display("FAIL post_rst_r_ready got %b exp 1", s_if.r_ready); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 6; i++) begin
      logic [3:0]  aid, rid_m;
      logic [31:0] aaddr, wd, rd, raddr;
      logic [5:0]  bid;
      logic        av, ardy, rv, wrdy;
      aid = 4'($urandom); aaddr = $urandom; wd = $urandom; rd = $urandom; raddr = $urandom;
      bid = 6'($urandom); av = 1'($urandom); ardy = 1'($urandom); rv = 1'($urandom);
      wrdy = 1'($urandom); rid_m = 4'($urandom);
      m_b.aw_id = aid; m_b.aw_addr = aaddr; m_b.aw_valid = av; s_b.aw_ready = ardy;
      m_b.w_data = wd; m_b.w_valid = 1'b1; s_b.w_ready = wrdy;
      s_b.b_id = bid; s_b.b_resp = 2'b11; s_b.b_valid = 1'b1; m_b.b_ready = 1'b1;
      m_b.ar_id = rid_m; m_b.ar_addr = raddr; m_b.ar_valid = 1'b1; s_b.ar_ready = 1'b1;
      s_b.r_data = rd; s_b.r_valid = rv; s_b.r_id = 6'h3F; m_b.r_ready = 1'b1;
      settle();
      n_total++; if (s_b.aw_id !== {2'b00, aid}) $display("FAIL byp_aw_id[%0d] got %h exp %h", i, s_b.aw_id, {2'b00, aid}); else n_pass++;
      n_total++; if (s_b.aw_addr !== aaddr[15:0]) $display("FAIL byp_aw_addr[%0d] got %h exp %h", i, s_b.aw_addr, aaddr[15:0]); else n_pass++;
      n_total++; if (s_b.aw_valid !== av) $display("FAIL byp_aw_valid[%0d] got %b exp %b", i, s_b.aw_valid, av); else n_pass++;
      n_total++; if (m_b.aw_ready !== ardy) $display("FAIL byp_aw_ready[%0d] got %b exp %b", i, m_b.aw_ready, ardy); else n_pass++;
      n_total++; if (s_b.w_data !== wd) $display("FAIL byp_w_data[%0d] got %h exp %h", i, s_b.w_data, wd); else n_pass++;
      n_total++; if (m_b.w_ready !== wrdy) $display("FAIL byp_w_ready[%0d] got %b exp %b", i, m_b.w_ready, wrdy); else n_pass++;
      n_total++; if (m_b.b_id !== bid[3:0]) $display("FAIL byp_b_id[%0d] got %h exp %h", i, m_b.b_id, bid[3:0]); else n_pass++;
      n_total++; if (s_b.ar_addr !== raddr[15:0]) $display("FAIL byp_ar_addr[%0d] got %h exp %h", i, s_b.ar_addr, raddr[15:0]); else n_pass++;
      n_total++; if (m_b.r_data !== rd || m_b.r_valid !== rv) $display("FAIL byp_r[%0d] got %h/%b exp %h/%b", i, m_b.r_data, m_b.r_valid, rd, rv); else n_pass++;
      tick();
    end
  endtask

  task automatic test_r_full();
    for (int k = 0; k < 10; k++) begin
      logic exp_v;
      s_if.r_valid = (k < 8);
      s_if.r_data  = 32'(k);
      s_if.r_last  = (k == 7);
      s_if.r_id    = 6'h3C;
      s_if.r_resp  = 2'b00;
      m_if.r_ready = 1'b1;
      settle();
      exp_v = (k >= 1 && k <= 8);
      n_total++; if (m_if.r_valid !== exp_v) $display("FAIL r_valid[%0d] got %b exp %b", k, m_if.r_valid, exp_v); else n_pass++;
      if (exp_v) begin
        n_total++; if (m_if.r_data !== 32'(k - 1)) $display("FAIL r_data[%0d] got %0d exp %0d", k, m_if.r_data, k - 1); else n_pass++;
        n_total++; if (m_if.r_last !== 1'(k == 8)) $display("FAIL r_last[%0d] got %b exp %b", k, m_if.r_last, k == 8); else n_pass++;
        n_total++; if (m_if.r_id !== 4'hC) $display("FAIL r_id[%0d] got %h exp c", k, m_if.r_id); else n_pass++;
      end
      if (k < 8) begin
        n_total++; if (s_if.r_ready !== 1'b1) $display("FAIL r_ready[%0d] got %b exp 1", k, s_if.r_ready); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_w_full();
    logic [31:0] mdat [7] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hCCCC_0003,
                              32'hCCCC_0003, 32'h0, 32'h0};
    logic [31:0] esd  [7] = '{32'h0, 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001,
                              32'hBBBB_0002, 32'hCCCC_0003, 32'h0};
    logic [6:0]  mv  = 7'b0011111;
    logic [6:0]  srd = 7'b1111000;
    logic [6:0]  emr = 7'b1110011;
    logic [6:0]  esv = 7'b0111110;
    for (int c = 0; c < 7; c++) begin
      m_if.w_valid = mv[c];
      m_if.w_data  = mdat[c];
      m_if.w_strb  = 4'hF;
      m_if.w_last  = (c >= 2);
      s_if.w_ready = srd[c];
      settle();
      n_total++; if (m_if.w_ready !== emr[c]) $display("FAIL w_ready[%0d] got %b exp %b", c, m_if.w_ready, emr[c]); else n_pass++;
      n_total++; if (s_if.w_valid !== esv[c]) $display("FAIL w_valid[%0d] got %b exp %b", c, s_if.w_valid, esv[c]); else n_pass++;
      if (esv[c]) begin
        n_total++; if (s_if.w_data !== esd[c]) $display("FAIL w_data[%0d] got %h exp %h", c, s_if.w_data, esd[c]); else n_pass++;
      end
      tick();
    end
    s_if.w_ready = 1'b0;
  endtask

  task automatic test_ar_half();
    logic [31:0] req [4] = '{32'hABCD_0100, 32'hABCD_0200, 32'hABCD_0300, 32'hABCD_0400};
    logic [15:0] exp_a [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    int idx  = 0;
    int ndel = 0;
    s_if.ar_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_if.ar_valid = (idx < 4);
      m_if.ar_addr  = req[(idx < 4) ? idx : 3];
      m_if.ar_id    = 4'(idx);
      settle();
      n_total++; if (m_if.ar_ready !== 1'(c % 2 == 0)) $display("FAIL ar_ready[%0d] got %b exp %b", c, m_if.ar_ready, c % 2 == 0); else n_pass++;
      n_total++; if (s_if.ar_valid !== 1'(c % 2 == 1)) $display("FAIL ar_valid[%0d] got %b exp %b", c, s_if.ar_valid, c % 2 == 1); else n_pass++;
      if (c % 2 == 1) begin
        n_total++; if (s_if.ar_addr !== exp_a[c / 2]) $display("FAIL ar_addr[%0d] got %h exp %h", c, s_if.ar_addr, exp_a[c / 2]); else n_pass++;
        n_total++; if (s_if.ar_id !== 6'(c / 2)) $display("FAIL ar_id[%0d] got %h exp %h", c, s_if.ar_id, c / 2); else n_pass++;
      end
      if (s_if.ar_valid && s_if.ar_ready) ndel++;
      if (m_if.ar_valid && m_if.ar_ready) idx++;
      tick();
    end
    m_if.ar_valid = 1'b0;
    n_total++; if (ndel !== 4) $display("FAIL ar_delivered got %0d exp 4", ndel); else n_pass++;
  endtask

  task automatic test_b_reset();
    s_if.b_valid = 1'b1; s_if.b_id = 6'h25; s_if.b_resp = 2'b10; s_if.b_user = 2'b01;
    m_if.b_ready = 1'b0;
    settle();
    n_total++; if (s_if.b_ready !== 1'b1) $display("FAIL b_ready_c0 got %b exp 1", s_if.b_ready); else n_pass++;
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL b_valid_c0 got %b exp 0", m_if.b_valid); else n_pass++;
    tick();
    s_if.b_valid = 1'b0;
    settle();
    n_total++; if (m_if.b_valid !== 1'b1) $display("FAIL b_valid_c1 got %b exp 1", m_if.b_valid); else n_pass++;
    n_total++; if (m_if.b_id !== 4'h5) $display("FAIL b_id_c1 got %h exp 5", m_if.b_id); else n_pass++;
    n_total++; if (s_if.b_ready !== 1'b0) $display("FAIL b_ready_c1 got %b exp 0", s_if.b_ready); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL b_valid_rst got %b exp 0", m_if.b_valid); else n_pass++;
    n_total++; if (m_if.b_resp !== 2'b00) $display("FAIL b_resp_rst got %b exp 00", m_if.b_resp); else n_pass++;
    n_total++; if (m_if.w_ready !== 1'b0) $display("FAIL w_ready_rst got %b exp 0", m_if.w_ready); else n_pass++;
    tick();
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL b_dup got %b exp 0", m_if.b_valid); else n_pass++;
    n_total++; if (m_if.w_ready !== 1'b1) $display("FAIL w_ready_after_rst got %b exp 1", m_if.w_ready); else n_pass++;
    s_if.b_valid = 1'b1; s_if.b_id = 6'h0A; s_if.b_resp = 2'b01; m_if.b_ready = 1'b1;
    settle();
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL b_lat0 got %b exp 0", m_if.b_valid); else n_pass++;
    tick();
    s_if.b_valid = 1'b0;
    settle();
    n_total++; if (m_if.b_valid !== 1'b1) $display("FAIL b_valid_lat1 got %b exp 1", m_if.b_valid); else n_pass++;
    n_total++; if (m_if.b_id !== 4'hA || m_if.b_resp !== 2'b01) $display("FAIL b_payload_lat1 got %h/%b exp a/01", m_if.b_id, m_if.b_resp); else n_pass++;
    tick();
    settle();
    n_total++; if (m_if.b_valid !== 1'b0) $display("FAIL b_drain got %b exp 0", m_if.b_valid); else n_pass++;
    tick();
  endtask

`ifdef AXI_REGSLICE_CHECK_EN
  task automatic test_checker();
    s_if.aw_ready = 1'b0;
    m_if.aw_valid = 1'b1;
    tick();
    m_if.aw_valid = 1'b0;
    tick();
    tick();
    settle();
    n_total++; if (dut.err_count !== 32'd1) $display("FAIL err_count got %0d exp 1", dut.err_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_r_full();
    test_w_full();
    test_ar_half();
    test_b_reset();
`ifdef AXI_REGSLICE_CHECK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
